// File: rtl/tps_pkg.sv
// ============================================================================
// Module      : tps_pkg
// Description : State codes, lamp patterns and sizing helpers for the
//               traffic phase scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tps_pkg;

  typedef enum logic [2:0] {
    S_A_GREEN  = 3'd0,
    S_A_YELLOW = 3'd1,
    S_RED_AB   = 3'd2,
    S_B_GREEN  = 3'd3,
    S_B_YELLOW = 3'd4,
    S_RED_BA   = 3'd5,
    S_WALK     = 3'd6,
    S_UNUSED   = 3'd7
  } state_e;

  localparam logic [2:0] LAMP_GREEN  = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_RED    = 3'b001;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic logic [2:0] lamp_a(input state_e s);
    case (s)
      S_A_GREEN:  return LAMP_GREEN;
      S_A_YELLOW: return LAMP_YELLOW;
      default:    return LAMP_RED;
    endcase
  endfunction

  function automatic logic [2:0] lamp_b(input state_e s);
    case (s)
      S_B_GREEN:  return LAMP_GREEN;
      S_B_YELLOW: return LAMP_YELLOW;
      default:    return LAMP_RED;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/tps_tick_timer.sv
// ============================================================================
// Module      : tps_tick_timer
// Description : Per-state TICK counter with clear and saturation; reports
//               threshold flags for n = cnt+1 (ticks including the current).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tps_tick_timer
  import tps_pkg::*;
#(
  parameter int MIN_GREEN    = 3,
  parameter int MAX_GREEN    = 6,
  parameter int YELLOW_TIME  = 2,
  parameter int ALL_RED_TIME = 1,
  parameter int WALK_TIME    = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic tick_i,
  input  logic clr_i,
  output logic min_ok_o,
  output logic max_ok_o,
  output logic yellow_done_o,
  output logic all_red_done_o,
  output logic walk_done_o
);

  // Saturating at the largest interval keeps every threshold reachable.
  localparam int SAT = max_int(max_int(MAX_GREEN, YELLOW_TIME), max_int(ALL_RED_TIME, WALK_TIME));
  localparam int CW  = cnt_width(SAT);

  localparam logic [CW-1:0] C_SAT  = SAT[CW-1:0];
  localparam logic [CW:0]   C_MIN  = MIN_GREEN[CW:0];
  localparam logic [CW:0]   C_MAX  = MAX_GREEN[CW:0];
  localparam logic [CW:0]   C_YEL  = YELLOW_TIME[CW:0];
  localparam logic [CW:0]   C_RED  = ALL_RED_TIME[CW:0];
  localparam logic [CW:0]   C_WALK = WALK_TIME[CW:0];

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [CW:0]   n;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (tick_i && (cnt_q != C_SAT))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign n              = {1'b0, cnt_q} + 1'b1;
  assign min_ok_o       = (n >= C_MIN);
  assign max_ok_o       = (n >= C_MAX);
  assign yellow_done_o  = (n == C_YEL);
  assign all_red_done_o = (n == C_RED);
  assign walk_done_o    = (n == C_WALK);

endmodule

`default_nettype wire

// File: rtl/traffic_phase_scheduler.sv
// ============================================================================
// Module      : traffic_phase_scheduler
// Description : Two-road green-time arbiter with min/max green, yellow and
//               all-red clearance. Optional pedestrian walk phase: TPS_PED_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module traffic_phase_scheduler
  import tps_pkg::*;
#(
  parameter int MIN_GREEN    = 3,
  parameter int MAX_GREEN    = 6,
  parameter int YELLOW_TIME  = 2,
  parameter int ALL_RED_TIME = 1,
  parameter int WALK_TIME    = 4
) (
  input  logic       CLK,
  input  logic       R_N,
  input  logic       TICK,
  input  logic       T_A,
  input  logic       T_B,
`ifdef TPS_PED_EN
  input  logic       PED_REQ,
  output logic       WALK,
`endif
  output logic [2:0] L_A,
  output logic [2:0] L_B,
  output logic [2:0] PHASE,
  output logic       CHANGE
);

`ifdef TPS_PED_EN
  localparam bit PED_EN = 1'b1;
`else
  localparam bit PED_EN = 1'b0;
`endif

  state_e     state_q, state_d;
  logic       walk_to_b_q, walk_to_b_d;
  logic [2:0] la_q, lb_q;
  logic       change_q;
  logic       ped_pend;
  logic       clr;
  logic       min_ok, max_ok, yellow_done, all_red_done, walk_done;

  tps_tick_timer #(
    .MIN_GREEN   (MIN_GREEN),
    .MAX_GREEN   (MAX_GREEN),
    .YELLOW_TIME (YELLOW_TIME),
    .ALL_RED_TIME(ALL_RED_TIME),
    .WALK_TIME   (WALK_TIME)
  ) u_timer (
    .clk_i         (CLK),
    .rst_ni        (R_N),
    .tick_i        (TICK),
    .clr_i         (clr),
    .min_ok_o      (min_ok),
    .max_ok_o      (max_ok),
    .yellow_done_o (yellow_done),
    .all_red_done_o(all_red_done),
    .walk_done_o   (walk_done)
  );

  // A pending pedestrian yields the active green as soon as MIN_GREEN is served.
  always_comb begin
    state_d     = state_q;
    walk_to_b_d = walk_to_b_q;
    case (state_q)
      S_A_GREEN:
        if (TICK && min_ok && (ped_pend || (T_B && (!T_A || max_ok))))
          state_d = S_A_YELLOW;
      S_B_GREEN:
        if (TICK && min_ok && (ped_pend || (T_A && (!T_B || max_ok))))
          state_d = S_B_YELLOW;
      S_A_YELLOW:
        if (TICK && yellow_done) begin
          if (ALL_RED_TIME != 0)      state_d = S_RED_AB;
          else if (ped_pend) begin    state_d = S_WALK; walk_to_b_d = 1'b1; end
          else                        state_d = S_B_GREEN;
        end
      S_B_YELLOW:
        if (TICK && yellow_done) begin
          if (ALL_RED_TIME != 0)      state_d = S_RED_BA;
          else if (ped_pend) begin    state_d = S_WALK; walk_to_b_d = 1'b0; end
          else                        state_d = S_A_GREEN;
        end
      S_RED_AB:
        if (TICK && all_red_done) begin
          if (ped_pend) begin state_d = S_WALK; walk_to_b_d = 1'b1; end
          else                state_d = S_B_GREEN;
        end
      S_RED_BA:
        if (TICK && all_red_done) begin
          if (ped_pend) begin state_d = S_WALK; walk_to_b_d = 1'b0; end
          else                state_d = S_A_GREEN;
        end
      S_WALK:
        if (!PED_EN)
          state_d = S_A_GREEN;
        else if (TICK && walk_done)
          state_d = walk_to_b_q ? S_B_GREEN : S_A_GREEN;
      default:
        state_d = S_A_GREEN;
    endcase
  end

  // Also covers recovery from unused codes, which happens without a TICK.
  assign clr = (state_d != state_q);

  always_ff @(posedge CLK or negedge R_N) begin
    if (!R_N) begin
      state_q     <= S_A_GREEN;
      walk_to_b_q <= 1'b0;
      la_q        <= LAMP_GREEN;
      lb_q        <= LAMP_RED;
      change_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      walk_to_b_q <= walk_to_b_d;
      la_q        <= lamp_a(state_d);
      lb_q        <= lamp_b(state_d);
      change_q    <= clr;
    end
  end

`ifdef TPS_PED_EN
  logic ped_pend_q, walk_q;

  always_ff @(posedge CLK or negedge R_N) begin
    if (!R_N) begin
      ped_pend_q <= 1'b0;
      walk_q     <= 1'b0;
    end else begin
      ped_pend_q <= (ped_pend_q && !(clr && state_d == S_WALK)) || PED_REQ;
      walk_q     <= (state_d == S_WALK);
    end
  end

  assign ped_pend = ped_pend_q;
  assign WALK     = walk_q;
`else
  assign ped_pend = 1'b0;
`endif

  assign L_A    = la_q;
  assign L_B    = lb_q;
  assign PHASE  = state_q;
  assign CHANGE = change_q;

endmodule

`default_nettype wire

// File: tb/tb_traffic_phase_scheduler.sv
// ============================================================================
// Module      : tb_traffic_phase_scheduler
// Description : Directed self-checking bench; TICK every 4 clocks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_traffic_phase_scheduler;

  logic       CLK    = 1'b0;
  logic       R_N    = 1'b0;
  logic       TICK   = 1'b0;
  logic       T_A    = 1'b0;
  logic       T_B    = 1'b0;
  logic       clk_en = 1'b1;
  logic [2:0] L_A, L_B, PHASE;
  logic       CHANGE;
`ifdef TPS_PED_EN
  logic       PED_REQ = 1'b0;
  logic       WALK;
`endif

  int errors = 0;
  int checks = 0;

  always begin
    #5;
    if (clk_en) CLK = ~CLK;
  end

  traffic_phase_scheduler #(
    .MIN_GREEN(3), .MAX_GREEN(6), .YELLOW_TIME(2), .ALL_RED_TIME(1), .WALK_TIME(4)
  ) dut (
    .CLK    (CLK),
    .R_N    (R_N),
    .TICK   (TICK),
    .T_A    (T_A),
    .T_B    (T_B),
`ifdef TPS_PED_EN
    .PED_REQ(PED_REQ),
    .WALK   (WALK),
`endif
    .L_A    (L_A),
    .L_B    (L_B),
    .PHASE  (PHASE),
    .CHANGE (CHANGE)
  );

  // Expected {L_A, L_B} for a phase code.
  function automatic logic [5:0] exp_lamps(input int ph);
    case (ph)
      0:       return {3'b100, 3'b001};
      1:       return {3'b010, 3'b001};
      3:       return {3'b001, 3'b100};
      4:       return {3'b001, 3'b010};
      default: return {3'b001, 3'b001};
    endcase
  endfunction

  task automatic do_reset();
    R_N  = 1'b0;
    TICK = 1'b0;
    T_A  = 1'b0;
    T_B  = 1'b0;
`ifdef TPS_PED_EN
    PED_REQ = 1'b0;
`endif
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    R_N = 1'b1;
  endtask

  task automatic tick_edge();
    @(negedge CLK);
    TICK = 1'b1;
    @(posedge CLK);
    #1;
    TICK = 1'b0;
  endtask

  task automatic idle();
    repeat (3) @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    R_N  = 1'b0;
    TICK = 1'b1;
    T_A  = 1'b0;
    T_B  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      repeat (2) @(posedge CLK);
      #1;
      checks++; if (L_A !== 3'b100) begin errors++; $display("FAIL reset_la[%0d] got=%b exp=100", i, L_A); end
      checks++; if (L_B !== 3'b001) begin errors++; $display("FAIL reset_lb[%0d] got=%b exp=001", i, L_B); end
      checks++; if (PHASE !== 3'd0) begin errors++; $display("FAIL reset_phase[%0d] got=%0d exp=0", i, PHASE); end
      checks++; if (CHANGE !== 1'b0) begin errors++; $display("FAIL reset_change[%0d] got=%b exp=0", i, CHANGE); end
    end
    @(negedge CLK);
    TICK = 1'b0;
    T_B  = 1'b0;
    R_N  = 1'b1;
  endtask

  task automatic test_single_demand();
    int ph[6] = '{0, 0, 1, 1, 2, 3};
    bit ch[6] = '{0, 0, 1, 0, 1, 1};
    do_reset();
    T_B = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick_edge();
      checks++; if (PHASE !== ph[i][2:0]) begin errors++; $display("FAIL single_phase[t%0d] got=%0d exp=%0d", i+1, PHASE, ph[i]); end
      checks++; if ({L_A, L_B} !== exp_lamps(ph[i])) begin errors++; $display("FAIL single_lamps[t%0d] got=%b_%b exp=%b", i+1, L_A, L_B, exp_lamps(ph[i])); end
      checks++; if (CHANGE !== ch[i]) begin errors++; $display("FAIL single_change[t%0d] got=%b exp=%b", i+1, CHANGE, ch[i]); end
      @(posedge CLK); #1;
      checks++; if (CHANGE !== 1'b0) begin errors++; $display("FAIL single_pulse_len[t%0d] got=%b exp=0", i+1, CHANGE); end
      repeat (2) @(posedge CLK);
    end
    for (int i = 0; i < 4; i++) begin
      tick_edge();
      checks++; if (PHASE !== 3'd3) begin errors++; $display("FAIL single_b_hold[%0d] got=%0d exp=3", i, PHASE); end
      idle();
    end
  endtask

  task automatic test_contended();
    int ph[24] = '{0,0,0,0,0,1,1,2,3,3,3,3,3,3,4,4,5,0,0,0,0,0,0,1};
    do_reset();
    T_A = 1'b1;
    T_B = 1'b1;
    for (int i = 0; i < 24; i++) begin
      tick_edge();
      checks++; if (PHASE !== ph[i][2:0]) begin errors++; $display("FAIL contended_phase[t%0d] got=%0d exp=%0d", i+1, PHASE, ph[i]); end
      checks++; if ({L_A, L_B} !== exp_lamps(ph[i])) begin errors++; $display("FAIL contended_lamps[t%0d] got=%b_%b exp=%b", i+1, L_A, L_B, exp_lamps(ph[i])); end
      checks++; if (L_A !== 3'b001 && L_B !== 3'b001) begin errors++; $display("FAIL contended_safety[t%0d] got=%b_%b exp=one_road_red", i+1, L_A, L_B); end
      idle();
    end
  endtask

  task automatic test_hold_no_demand();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      tick_edge();
      checks++; if (PHASE !== 3'd0) begin errors++; $display("FAIL hold_phase[t%0d] got=%0d exp=0", i+1, PHASE); end
      idle();
    end
    T_B = 1'b1;
    tick_edge();
    checks++; if (PHASE !== 3'd1) begin errors++; $display("FAIL hold_release_phase got=%0d exp=1", PHASE); end
    checks++; if (CHANGE !== 1'b1) begin errors++; $display("FAIL hold_release_change got=%b exp=1", CHANGE); end
    checks++; if (L_A !== 3'b010) begin errors++; $display("FAIL hold_release_la got=%b exp=010", L_A); end
    idle();
  endtask

  task automatic test_async_reset();
    int ph[3] = '{0, 0, 1};
    do_reset();
    T_B = 1'b1;
    repeat (3) tick_edge();
    checks++; if (PHASE !== 3'd1) begin errors++; $display("FAIL async_pre_phase got=%0d exp=1", PHASE); end
    @(negedge CLK);
    clk_en = 1'b0;
    #3;
    R_N = 1'b0;
    #1;
    checks++; if (L_A !== 3'b100) begin errors++; $display("FAIL async_la got=%b exp=100", L_A); end
    checks++; if (L_B !== 3'b001) begin errors++; $display("FAIL async_lb got=%b exp=001", L_B); end
    checks++; if (PHASE !== 3'd0) begin errors++; $display("FAIL async_phase got=%0d exp=0", PHASE); end
    checks++; if (CHANGE !== 1'b0) begin errors++; $display("FAIL async_change got=%b exp=0", CHANGE); end
    #5;
    R_N = 1'b1;
    #2;
    clk_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick_edge();
      checks++; if (PHASE !== ph[i][2:0]) begin errors++; $display("FAIL async_restart[t%0d] got=%0d exp=%0d", i+1, PHASE, ph[i]); end
      idle();
    end
  endtask

`ifdef TPS_PED_EN
  task automatic test_pedestrian();
    int ph[10] = '{0, 0, 1, 1, 2, 6, 6, 6, 6, 3};
    bit wk[10] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 0};
    do_reset();
    T_A = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      TICK    = 1'b1;
      PED_REQ = (i == 0);
      @(posedge CLK);
      #1;
      TICK    = 1'b0;
      PED_REQ = 1'b0;
      checks++; if (PHASE !== ph[i][2:0]) begin errors++; $display("FAIL ped_phase[t%0d] got=%0d exp=%0d", i+1, PHASE, ph[i]); end
      checks++; if (WALK !== wk[i]) begin errors++; $display("FAIL ped_walk[t%0d] got=%b exp=%b", i+1, WALK, wk[i]); end
      checks++; if ({L_A, L_B} !== exp_lamps(ph[i])) begin errors++; $display("FAIL ped_lamps[t%0d] got=%b_%b exp=%b", i+1, L_A, L_B, exp_lamps(ph[i])); end
      idle();
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_demand();
    test_contended();
    test_hold_no_demand();
    test_async_reset();
`ifdef TPS_PED_EN
    test_pedestrian();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
